// File: rtl/udp_checksum_check.sv
// UDP receive-side checker: forwards header and 8-bit payload unchanged while
// verifying the one's-complement checksum and the UDP length of every datagram.
module udp_checksum_check #(
  parameter int ERR_CNT_WIDTH = 16,
  parameter int ID_WIDTH      = 8,
  parameter int DEST_WIDTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  // inbound header
  input  logic                     s_udp_hdr_valid_i,
  output logic                     s_udp_hdr_ready_o,
  input  logic [31:0]              s_udp_ip_source_ip_i,
  input  logic [31:0]              s_udp_ip_dest_ip_i,
  input  logic [15:0]              s_udp_source_port_i,
  input  logic [15:0]              s_udp_dest_port_i,
  input  logic [15:0]              s_udp_length_i,
  input  logic [15:0]              s_udp_checksum_i,
  // inbound payload
  input  logic [7:0]               s_axis_tdata_i,
  input  logic [0:0]               s_axis_tkeep_i,
  input  logic                     s_axis_tvalid_i,
  output logic                     s_axis_tready_o,
  input  logic                     s_axis_tlast_i,
  input  logic [ID_WIDTH-1:0]      s_axis_tid_i,
  input  logic [DEST_WIDTH-1:0]    s_axis_tdest_i,
  // outbound header
  output logic                     m_udp_hdr_valid_o,
  input  logic                     m_udp_hdr_ready_i,
  output logic [31:0]              m_udp_ip_source_ip_o,
  output logic [31:0]              m_udp_ip_dest_ip_o,
  output logic [15:0]              m_udp_source_port_o,
  output logic [15:0]              m_udp_dest_port_o,
  output logic [15:0]              m_udp_length_o,
  output logic [15:0]              m_udp_checksum_o,
  // outbound payload
  output logic [7:0]               m_axis_tdata_o,
  output logic [0:0]               m_axis_tkeep_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     m_axis_tlast_o,
  output logic [ID_WIDTH-1:0]      m_axis_tid_o,
  output logic [DEST_WIDTH-1:0]    m_axis_tdest_o,
  output logic [0:0]               m_axis_tuser_o,
  // status
  output logic                     checksum_err_o,
  output logic                     length_err_o,
  output logic [ERR_CNT_WIDTH-1:0] checksum_err_count_o,
  output logic [ERR_CNT_WIDTH-1:0] length_err_count_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR_OUT = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

  state_t                   state_q, state_d;
  logic                     alive_q;
  logic [31:0]              sip_q, sip_d;
  logic [31:0]              dip_q, dip_d;
  logic [15:0]              sport_q, sport_d;
  logic [15:0]              dport_q, dport_d;
  logic [15:0]              len_q, len_d;
  logic [15:0]              csum_q, csum_d;
  logic [31:0]              acc_q, acc_d;
  logic [15:0]              cnt_q, cnt_d;
  logic                     cs_err_q, cs_err_d;
  logic                     len_err_q, len_err_d;
  logic [ERR_CNT_WIDTH-1:0] cs_cnt_q, cs_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] len_cnt_q, len_cnt_d;

  logic        in_payload_s;
  logic        hdr_fire_s;
  logic        beat_fire_s;
  logic [31:0] hdr_sum_s;
  logic [15:0] byte_word_s;
  logic [31:0] sum_s;
  logic [16:0] fold1_s;
  logic [16:0] fold2_s;
  logic [15:0] folded_s;
  logic        cs_bad_s;
  logic        len_bad_s;

  // Header readiness waits one clock after reset so it is never seen high in reset.
  assign s_udp_hdr_ready_o = (state_q == ST_IDLE) && alive_q;
  assign hdr_fire_s        = s_udp_hdr_valid_i && s_udp_hdr_ready_o;
  assign in_payload_s      = (state_q == ST_PAYLOAD);
  assign beat_fire_s       = in_payload_s && s_axis_tvalid_i && m_axis_tready_i;

  // Pseudo-header plus UDP header; the length appears twice (pseudo and UDP).
  assign hdr_sum_s = {16'h0000, s_udp_ip_source_ip_i[31:16]} + {16'h0000, s_udp_ip_source_ip_i[15:0]}
                   + {16'h0000, s_udp_ip_dest_ip_i[31:16]}   + {16'h0000, s_udp_ip_dest_ip_i[15:0]}
                   + 32'h0000_0011                           + {16'h0000, s_udp_length_i}
                   + {16'h0000, s_udp_source_port_i}         + {16'h0000, s_udp_dest_port_i}
                   + {16'h0000, s_udp_length_i}              + {16'h0000, s_udp_checksum_i};

  assign byte_word_s = cnt_q[0] ? {8'h00, s_axis_tdata_i} : {s_axis_tdata_i, 8'h00};
  assign sum_s       = acc_q + {16'h0000, byte_word_s};
  assign fold1_s     = {1'b0, sum_s[15:0]} + {1'b0, sum_s[31:16]};
  assign fold2_s     = {1'b0, fold1_s[15:0]} + {16'h0000, fold1_s[16]};
  assign folded_s    = fold2_s[15:0];

  // A transmitted checksum of zero means the sender did not compute one.
  assign cs_bad_s  = (csum_q != 16'h0000) && (folded_s != 16'hFFFF);
  assign len_bad_s = (len_q < 16'd8) ||
                     (({1'b0, cnt_q} + 17'd1) != ({1'b0, len_q} - 17'd8));

  // State, header copy, accumulator and error bookkeeping registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      alive_q   <= 1'b0;
      sip_q     <= 32'h0000_0000;
      dip_q     <= 32'h0000_0000;
      sport_q   <= 16'h0000;
      dport_q   <= 16'h0000;
      len_q     <= 16'h0000;
      csum_q    <= 16'h0000;
      acc_q     <= 32'h0000_0000;
      cnt_q     <= 16'h0000;
      cs_err_q  <= 1'b0;
      len_err_q <= 1'b0;
      cs_cnt_q  <= {ERR_CNT_WIDTH{1'b0}};
      len_cnt_q <= {ERR_CNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      alive_q   <= 1'b1;
      sip_q     <= sip_d;
      dip_q     <= dip_d;
      sport_q   <= sport_d;
      dport_q   <= dport_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      cs_err_q  <= cs_err_d;
      len_err_q <= len_err_d;
      cs_cnt_q  <= cs_cnt_d;
      len_cnt_q <= len_cnt_d;
    end
  end

  // Next-state logic: header latch, per-beat accumulation, verdict on the last beat.
  always_comb begin
    state_d   = state_q;
    sip_d     = sip_q;
    dip_d     = dip_q;
    sport_d   = sport_q;
    dport_d   = dport_q;
    len_d     = len_q;
    csum_d    = csum_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    cs_err_d  = 1'b0;
    len_err_d = 1'b0;
    cs_cnt_d  = cs_cnt_q;
    len_cnt_d = len_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_fire_s) begin
          sip_d   = s_udp_ip_source_ip_i;
          dip_d   = s_udp_ip_dest_ip_i;
          sport_d = s_udp_source_port_i;
          dport_d = s_udp_dest_port_i;
          len_d   = s_udp_length_i;
          csum_d  = s_udp_checksum_i;
          acc_d   = hdr_sum_s;
          cnt_d   = 16'h0000;
          state_d = ST_HDR_OUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR_OUT: begin
        if (m_udp_hdr_ready_i) begin
          state_d = ST_PAYLOAD;
        end else begin
          state_d = ST_HDR_OUT;
        end
      end
      ST_PAYLOAD: begin
        if (beat_fire_s) begin
          acc_d = sum_s;
          cnt_d = cnt_q + 16'd1;
          if (s_axis_tlast_i) begin
            cs_err_d  = cs_bad_s;
            len_err_d = len_bad_s;
            if (cs_bad_s && (cs_cnt_q != CNT_MAX)) begin
              cs_cnt_d = cs_cnt_q + CNT_ONE;
            end else begin
              cs_cnt_d = cs_cnt_q;
            end
            if (len_bad_s && (len_cnt_q != CNT_MAX)) begin
              len_cnt_d = len_cnt_q + CNT_ONE;
            end else begin
              len_cnt_d = len_cnt_q;
            end
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign m_udp_hdr_valid_o    = (state_q == ST_HDR_OUT);
  assign m_udp_ip_source_ip_o = sip_q;
  assign m_udp_ip_dest_ip_o   = dip_q;
  assign m_udp_source_port_o  = sport_q;
  assign m_udp_dest_port_o    = dport_q;
  assign m_udp_length_o       = len_q;
  assign m_udp_checksum_o     = csum_q;

  // Payload is a zero-latency wire path, forced to zero outside PAYLOAD.
  assign s_axis_tready_o = in_payload_s && m_axis_tready_i;
  assign m_axis_tvalid_o = in_payload_s && s_axis_tvalid_i;
  assign m_axis_tdata_o  = in_payload_s ? s_axis_tdata_i : 8'h00;
  assign m_axis_tkeep_o  = in_payload_s ? s_axis_tkeep_i : 1'b0;
  assign m_axis_tlast_o  = in_payload_s && s_axis_tlast_i;
  assign m_axis_tid_o    = in_payload_s ? s_axis_tid_i : {ID_WIDTH{1'b0}};
  assign m_axis_tdest_o  = in_payload_s ? s_axis_tdest_i : {DEST_WIDTH{1'b0}};
  assign m_axis_tuser_o  = in_payload_s && s_axis_tvalid_i && s_axis_tlast_i &&
                           (cs_bad_s || len_bad_s);

  assign checksum_err_o       = cs_err_q;
  assign length_err_o         = len_err_q;
  assign checksum_err_count_o = cs_cnt_q;
  assign length_err_count_o   = len_cnt_q;
  assign busy_o               = (state_q != ST_IDLE);

endmodule
